div: RTL
========

Name: div

Overview:
- Sequential integer divider for SVLib arith; the inverse of the Booth multiplier.
- Computes quotient and remainder of a / b, one quotient bit per cycle (radix-2 restoring).
- Supports signed and unsigned operands, selected by an `unsign` input with the same meaning as on the multiplier.
- valid/ready handshake on input and output, so it drops into pipelined datapaths next to `mul`.

Parameters:
- WIDTH, 16, operand, quotient and remainder width in bits (>= 2).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset; synchronous and active-low.
- in_valid  input  1  operands valid.
- in_ready  output  1  divider can accept operands.
- a  input  WIDTH  dividend.
- b  input  WIDTH  divisor.
- unsign  input  1  1: unsigned operation; 0: two's-complement signed.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- quotient  output  WIDTH  quotient, truncated toward zero.
- remainder  output  WIDTH  remainder; sign follows the dividend (signed mode).
- div_by_zero  output  1  result came from b == 0.
- overflow  output  1  result came from signed most-negative / -1.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - state=IDLE; in_ready=1; out_valid=0.
  - quotient, remainder, div_by_zero, overflow = 0.
  - Iteration counter cleared.
  - Reset takes priority over every other event, including a mid-division BUSY state; the partial result is discarded.
- States: IDLE, BUSY, FIX, DONE.
- in_ready = (state==IDLE). out_valid = (state==DONE).
- IDLE: on in_valid && in_ready, register operands and flags, then:
  - b==0 -> DONE next cycle.
    - quotient = all ones.
    - remainder = a.
    - div_by_zero=1, overflow=0.
  - else if unsign==0, a==100..0 and b==all ones -> DONE next cycle.
    - quotient = a.
    - remainder = 0.
    - overflow=1, div_by_zero=0.
  - else -> BUSY.
    - Store |a| and |b| (unsigned mode: raw values).
    - Record neg_q = a_sign ^ b_sign and neg_r = a_sign (signed mode only).
    - Counter = WIDTH.
- BUSY: one iteration per cycle.
  - Partial remainder (WIDTH+1 bits) shifts left, taking the next dividend MSB.
  - Trial-subtract |b|. If the result is non-negative, keep it and shift in quotient bit 1; else restore and shift in 0.
  - Counter decrements. After exactly WIDTH BUSY cycles -> FIX.
- FIX: single cycle.
  - quotient = neg_q ? -q : q.
  - remainder = neg_r ? -r : r.
  - Flags = 0. Then -> DONE.
- DONE: hold all outputs stable while out_valid && !out_ready.
  - On out_ready -> IDLE; in_ready rises the following cycle (no same-cycle accept).
  - Outputs retain their last value in IDLE; only out_valid qualifies them.
- Latency, accept edge to first cycle with out_valid=1:
  - Normal: WIDTH+2 cycles.
  - Zero-divisor and signed-overflow cases: 1 cycle.
- Throughput: one division outstanding. in_valid while busy is ignored; the source must hold it.
- Invariant (non-special cases): a == quotient*b + remainder, with |remainder| < |b|.
- Unsign is sampled only at accept. Changes during BUSY have no effect.

Test Plan:
- WIDTH=16, unsign=1, a=100, b=7 -> quotient=14, remainder=2, flags 0, out_valid exactly 18 cycles after accept.
- unsign=0, a=0xFFF9 (-7), b=2 -> quotient=0xFFFD (-3), remainder=0xFFFF (-1). Repeat with a=7, b=0xFFFE -> quotient=0xFFFD, remainder=0x0001.
- a=0x1234, b=0, either mode -> quotient=0xFFFF, remainder=0x1234, div_by_zero=1, out_valid 1 cycle after accept.
- unsign=0, a=0x8000, b=0xFFFF -> quotient=0x8000, remainder=0, overflow=1. Same operands with unsign=1 -> quotient=0, remainder=0x8000, overflow=0, full latency.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0 throughout. Raise out_ready -> IDLE, then accept a new operand pair the next cycle.
- Reset mid-operation: assert rst_n=0 at iteration 8 -> next cycle IDLE, in_ready=1, out_valid=0, outputs zero. A new division (0xFFFF/0x0003, unsigned) -> quotient=0x5555, remainder=0.

Source files
------------

// File: rtl/div.sv
// Sequential radix-2 restoring divider producing quotient and remainder.
// Signed or unsigned operation is chosen per division by `unsign`, which is
// sampled only when the operands are accepted. A division by zero and the
// signed most-negative / -1 case are resolved at accept time and skip the
// iteration loop. A normal division runs WIDTH iterations and then one sign
// fix-up cycle.
//
// Handshake: an input transfer happens on a rising edge where in_valid and
// in_ready are both high. An output transfer happens on a rising edge where
// out_valid and out_ready are both high. The producer must hold its data
// stable until its transfer edge. in_valid has no effect while the divider is
// busy, so the source must keep asserting it.
module div #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             unsign,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // The state register is visible as `state` for checkers to bind to.
    state_t state;
    state_t state_next;

    logic [CW-1:0]    count;     // iterations still to run
    logic [WIDTH-1:0] rem_q;     // partial remainder (always < divisor)
    logic [WIDTH-1:0] dq_q;      // dividend bits shifting out, quotient bits shifting in
    logic [WIDTH-1:0] dvs_q;     // divisor magnitude
    logic             neg_quo;   // negate quotient during fix-up
    logic             neg_rem;   // negate remainder during fix-up

    logic             take;
    logic             b_zero;
    logic             s_ovf;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   rem_diff;

    // Accept decode, special-case detection and operand magnitudes.
    always_comb begin
        take   = in_valid && in_ready;
        b_zero = (b == '0);
        s_ovf  = !unsign && (a == MOST_NEG) && (b == '1);
        a_neg  = !unsign && a[WIDTH-1];
        b_neg  = !unsign && b[WIDTH-1];
        a_abs  = a_neg ? -a : a;
        b_abs  = b_neg ? -b : b;
    end

    // One restoring step: shift in the next dividend bit, then trial-subtract.
    always_comb begin
        rem_sh   = {rem_q, dq_q[WIDTH-1]};
        rem_diff = rem_sh - {1'b0, dvs_q};
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (take) begin
                    state_next = (b_zero || s_ovf) ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (count == CW'(1)) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                state_next = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Datapath: operand capture, iteration and sign fix-up.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count       <= '0;
            rem_q       <= '0;
            dq_q        <= '0;
            dvs_q       <= '0;
            neg_quo     <= 1'b0;
            neg_rem     <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (take) begin
                        if (b_zero) begin
                            quotient    <= '1;
                            remainder   <= a;
                            div_by_zero <= 1'b1;
                            overflow    <= 1'b0;
                        end else if (s_ovf) begin
                            quotient    <= a;
                            remainder   <= '0;
                            div_by_zero <= 1'b0;
                            overflow    <= 1'b1;
                        end else begin
                            rem_q   <= '0;
                            dq_q    <= a_abs;
                            dvs_q   <= b_abs;
                            neg_quo <= a_neg ^ b_neg;
                            neg_rem <= a_neg;
                            count   <= CW'(WIDTH);
                        end
                    end
                end
                BUSY: begin
                    if (!rem_diff[WIDTH]) begin
                        rem_q <= rem_diff[WIDTH-1:0];
                        dq_q  <= {dq_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_q <= rem_sh[WIDTH-1:0];
                        dq_q  <= {dq_q[WIDTH-2:0], 1'b0};
                    end
                    count <= count - CW'(1);
                end
                FIX: begin
                    quotient    <= neg_quo ? -dq_q : dq_q;
                    remainder   <= neg_rem ? -rem_q : rem_q;
                    div_by_zero <= 1'b0;
                    overflow    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
